// File: rtl/spdif_decode.sv
// spdif_decode: biphase-mark S/PDIF receiver. Measures the time between input edges,
// classifies each pulse as 1, 2 or 3 unit intervals, recognizes B/M/W preambles, and
// assembles 24-bit left/right sample pairs with even-parity checking.
module spdif_decode #(
  parameter int unsigned T_SHORT_MAX = 9,
  parameter int unsigned T_MED_MAX   = 15,
  parameter int unsigned T_LONG_MAX  = 22
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spdif,
  output logic [23:0] sample_left,
  output logic [23:0] sample_right,
  output logic        sample_valid,
  output logic        block_start,
  output logic        locked,
  output logic        parity_error
);

  localparam int unsigned CntW = $clog2(T_LONG_MAX + 2);
  localparam logic [CntW-1:0] ShortMax = CntW'(T_SHORT_MAX);
  localparam logic [CntW-1:0] MedMax   = CntW'(T_MED_MAX);
  localparam logic [CntW-1:0] LongMax  = CntW'(T_LONG_MAX);
  localparam logic [CntW-1:0] SatVal   = CntW'(T_LONG_MAX + 1);

  typedef enum logic [1:0] {StHunt, StPre, StData} state_e;
  typedef enum logic [1:0] {PulS, PulM, PulL, PulBad} pulse_e;
  typedef enum logic [1:0] {SubB, SubM, SubW} sub_e;

  logic            sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  state_e          state_q, state_d;
  logic [1:0]      pre_idx_q, pre_idx_d;
  sub_e            pre_kind_q, pre_kind_d;
  sub_e            sub_q, sub_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic            half_q, half_d;
  logic [27:0]     sr_q, sr_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_b_q, pend_b_d;
  logic [23:0]     pend_left_q, pend_left_d;
  logic [23:0]     left_q, left_d, right_q, right_d;
  logic            block_q, block_d;
  logic            locked_q, locked_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;

  logic   edge_det, timeout, fail, bit_ok, bit_val;
  pulse_e pulse;

  // Synchronizer chain plus one extra stage holding the previous level for edge detection.
  always_comb begin
    sync1_d  = spdif;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    edge_det = sync2_q ^ sync3_q;
  end

  // Pulse-length counter: restarts at 1 on an edge, saturates one past the long limit.
  always_comb begin
    if (edge_det) begin
      cnt_d = CntW'(1);
    end else if (cnt_q == SatVal) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    timeout = !edge_det && (cnt_q == SatVal);
    // cnt_q is the length of the pulse that ends at this edge.
    if (cnt_q == '0) begin
      pulse = PulBad;
    end else if (cnt_q <= ShortMax) begin
      pulse = PulS;
    end else if (cnt_q <= MedMax) begin
      pulse = PulM;
    end else if (cnt_q <= LongMax) begin
      pulse = PulL;
    end else begin
      pulse = PulBad;
    end
  end

  // Preamble/data decoder, subframe pairing and output strobes.
  always_comb begin
    state_d      = state_q;
    pre_idx_d    = pre_idx_q;
    pre_kind_d   = pre_kind_q;
    sub_d        = sub_q;
    bit_cnt_d    = bit_cnt_q;
    half_d       = half_q;
    sr_d         = sr_q;
    pend_valid_d = pend_valid_q;
    pend_b_d     = pend_b_q;
    pend_left_d  = pend_left_q;
    left_d       = left_q;
    right_d      = right_q;
    block_d      = block_q;
    locked_d     = locked_q;
    valid_d      = 1'b0;
    perr_d       = 1'b0;
    fail         = 1'b0;
    bit_ok       = 1'b0;
    bit_val      = 1'b0;

    if (timeout) begin
      fail = 1'b1;
    end else if (edge_det) begin
      unique case (state_q)
        StHunt: begin
          if (pulse == PulL) begin
            state_d   = StPre;
            pre_idx_d = 2'd1;
          end
        end
        StPre: begin
          unique case (pre_idx_q)
            2'd0: begin
              if (pulse == PulL) pre_idx_d = 2'd1;
              else fail = 1'b1;
            end
            2'd1: begin
              pre_idx_d = 2'd2;
              unique case (pulse)
                PulS:    pre_kind_d = SubB;
                PulL:    pre_kind_d = SubM;
                PulM:    pre_kind_d = SubW;
                default: fail = 1'b1;
              endcase
            end
            2'd2: begin
              if (pulse == PulS) pre_idx_d = 2'd3;
              else fail = 1'b1;
            end
            default: begin
              if ((pre_kind_q == SubB && pulse == PulL) ||
                  (pre_kind_q == SubM && pulse == PulS) ||
                  (pre_kind_q == SubW && pulse == PulM)) begin
                locked_d  = 1'b1;
                state_d   = StData;
                bit_cnt_d = 5'd0;
                half_d    = 1'b0;
                sub_d     = pre_kind_q;
              end else begin
                fail = 1'b1;
              end
            end
          endcase
        end
        StData: begin
          if (pulse == PulS) begin
            if (half_q) begin
              bit_ok  = 1'b1;
              bit_val = 1'b1;
              half_d  = 1'b0;
            end else begin
              half_d = 1'b1;
            end
          end else if (pulse == PulM && !half_q) begin
            bit_ok  = 1'b1;
            bit_val = 1'b0;
          end else begin
            fail = 1'b1;
          end
        end
        default: fail = 1'b1;
      endcase
    end

    // Bits arrive LSB first, so shift in at the top; after 28 bits slot 4 sits at bit 0.
    if (bit_ok) begin
      sr_d = {bit_val, sr_q[27:1]};
      if (bit_cnt_q == 5'd27) begin
        state_d   = StPre;
        pre_idx_d = 2'd0;
        if (^sr_d) begin
          perr_d       = 1'b1;
          pend_valid_d = 1'b0;
        end else if (sub_q == SubW) begin
          if (pend_valid_q) begin
            left_d  = pend_left_q;
            right_d = sr_d[23:0];
            block_d = pend_b_q;
            valid_d = 1'b1;
          end
          pend_valid_d = 1'b0;
        end else begin
          pend_valid_d = 1'b1;
          pend_left_d  = sr_d[23:0];
          pend_b_d     = (sub_q == SubB);
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    // Loss of sync; an offending L pulse may itself be the start of the next preamble.
    if (fail) begin
      locked_d     = 1'b0;
      pend_valid_d = 1'b0;
      half_d       = 1'b0;
      if (edge_det && pulse == PulL) begin
        state_d   = StPre;
        pre_idx_d = 2'd1;
      end else begin
        state_d = StHunt;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      cnt_q        <= '0;
      state_q      <= StHunt;
      pre_idx_q    <= 2'd0;
      pre_kind_q   <= SubB;
      sub_q        <= SubB;
      bit_cnt_q    <= 5'd0;
      half_q       <= 1'b0;
      sr_q         <= 28'd0;
      pend_valid_q <= 1'b0;
      pend_b_q     <= 1'b0;
      pend_left_q  <= 24'd0;
      left_q       <= 24'd0;
      right_q      <= 24'd0;
      block_q      <= 1'b0;
      locked_q     <= 1'b0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      pre_idx_q    <= pre_idx_d;
      pre_kind_q   <= pre_kind_d;
      sub_q        <= sub_d;
      bit_cnt_q    <= bit_cnt_d;
      half_q       <= half_d;
      sr_q         <= sr_d;
      pend_valid_q <= pend_valid_d;
      pend_b_q     <= pend_b_d;
      pend_left_q  <= pend_left_d;
      left_q       <= left_d;
      right_q      <= right_d;
      block_q      <= block_d;
      locked_q     <= locked_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign block_start  = block_q;
  assign locked       = locked_q;
  assign parity_error = perr_q;

endmodule

// File: tb/tb_spdif_decode.sv
// tb_spdif_decode: drives biphase-mark subframe streams (38.4 MHz clk, 162 ns UI with
// small jitter) and compares decoded pairs and parity strobes against a pairing model.
`timescale 1ns/1ps
module tb_spdif_decode;

  localparam real ClkHalf = 13.0208;
  localparam real Ui      = 162.0;

  typedef struct packed {
    logic [1:0]  kind;  // 0 = B, 1 = M, 2 = W
    logic [23:0] data;
    logic        bad;   // corrupt one audio bit after computing parity
    logic        trunc; // stop after 10 bits and hold the line
  } sf_t;

  typedef struct packed {
    logic        blk;
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spdif = 1'b0;
  logic [23:0] sample_left, sample_right;
  logic        sample_valid, block_start, locked, parity_error;

  int      checks = 0;
  int      errors = 0;
  sf_t     stim[$];
  pair_t   exp_q[$];
  int      exp_pe;
  pair_t   obs[$];
  int      pe_total = 0;
  int      lock_rises = 0;
  realtime lock_t = 0.0;
  realtime start_t = 0.0;

  spdif_decode dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spdif        (spdif),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .block_start  (block_start),
    .locked       (locked),
    .parity_error (parity_error)
  );

  always #(ClkHalf) clk = ~clk;

  // Observe strobes away from the active edge.
  always @(negedge clk) begin
    pair_t p;
    if (sample_valid) begin
      p.blk = block_start;
      p.l   = sample_left;
      p.r   = sample_right;
      obs.push_back(p);
    end
    if (parity_error) pe_total++;
  end

  always @(posedge locked) begin
    lock_t = $realtime;
    lock_rises++;
  end

  function automatic sf_t mk(input logic [1:0] k, input logic [23:0] d, input logic b,
                             input logic t);
    sf_t s;
    s.kind  = k;
    s.data  = d;
    s.bad   = b;
    s.trunc = t;
    return s;
  endfunction

  task automatic wait_clks(input int n);
    #(n * 2.0 * ClkHalf);
  endtask

  task automatic send_pulse(input int n_ui);
    real j;
    j = real'($urandom_range(12)) - 6.0;
    spdif = ~spdif;
    #(n_ui * Ui + j);
  endtask

  task automatic send_subframe(input sf_t s);
    logic [27:0] w;
    int          pre[4];
    int          idx;
    int          nbits;
    w[23:0]  = s.data;
    w[26:24] = 3'($urandom);
    w[27]    = ^w[26:0];
    if (s.bad) begin
      idx    = $urandom_range(23);
      w[idx] = ~w[idx];
    end
    case (s.kind)
      2'd0:    pre = '{3, 1, 1, 3};
      2'd1:    pre = '{3, 3, 1, 1};
      default: pre = '{3, 2, 1, 2};
    endcase
    for (int i = 0; i < 4; i++) send_pulse(pre[i]);
    nbits = s.trunc ? 10 : 28;
    for (int i = 0; i < nbits; i++) begin
      if (w[i]) begin
        send_pulse(1);
        send_pulse(1);
      end else begin
        send_pulse(2);
      end
    end
    if (s.trunc) wait_clks(30);
  endtask

  // Idle, the whole stim queue, a terminating edge for the last pulse, then idle again.
  task automatic run_stream(input logic inv);
    spdif = inv;
    wait_clks(40);
    start_t = $realtime;
    foreach (stim[i]) send_subframe(stim[i]);
    spdif = ~spdif;
    wait_clks(40);
  endtask

  // Pairing rules: B/M holds a pending left, a good W completes it, anything else drops it.
  task automatic build_model();
    logic        pend;
    logic [23:0] pl;
    logic        pb;
    pair_t       p;
    pend = 1'b0;
    pl   = '0;
    pb   = 1'b0;
    exp_q.delete();
    exp_pe = 0;
    foreach (stim[i]) begin
      if (stim[i].trunc) begin
        pend = 1'b0;
      end else if (stim[i].bad) begin
        exp_pe++;
        pend = 1'b0;
      end else if (stim[i].kind != 2'd2) begin
        pend = 1'b1;
        pl   = stim[i].data;
        pb   = (stim[i].kind == 2'd0);
      end else begin
        if (pend) begin
          p.blk = pb;
          p.l   = pl;
          p.r   = stim[i].data;
          exp_q.push_back(p);
        end
        pend = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    wait_clks(4);
    checks++;
    if (sample_left !== 24'd0 || sample_right !== 24'd0) begin
      errors++;
      $display("FAIL reset_samples: got %h/%h expected 000000/000000", sample_left, sample_right);
    end
    checks++;
    if (sample_valid !== 1'b0 || block_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got valid=%b block=%b expected 0/0", sample_valid, block_start);
    end
    checks++;
    if (locked !== 1'b0 || parity_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got locked=%b perr=%b expected 0/0", locked, parity_error);
    end
    reset_n = 1'b1;
    wait_clks(4);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_locked: got %b expected 0", locked);
    end
  endtask

  task automatic test_directed();
    int    base, pe0;
    pair_t e0, e1;
    realtime dt;
    stim.delete();
    stim.push_back(mk(2'd0, 24'hABCDEF, 1'b0, 1'b0));
    stim.push_back(mk(2'd2, 24'h123456, 1'b0, 1'b0));
    stim.push_back(mk(2'd1, 24'h000001, 1'b0, 1'b0));
    stim.push_back(mk(2'd2, 24'hFFFFFF, 1'b0, 1'b0));
    e0 = {1'b1, 24'hABCDEF, 24'h123456};
    e1 = {1'b0, 24'h000001, 24'hFFFFFF};
    base = obs.size();
    pe0  = pe_total;
    run_stream(1'b0);
    checks++;
    if (obs.size() - base != 2) begin
      errors++;
      $display("FAIL directed_count: got %0d expected 2", obs.size() - base);
    end
    if (obs.size() - base >= 1) begin
      checks++;
      if (obs[base] !== e0) begin
        errors++;
        $display("FAIL directed_pair0: got %h expected %h", obs[base], e0);
      end
    end
    if (obs.size() - base >= 2) begin
      checks++;
      if (obs[base+1] !== e1) begin
        errors++;
        $display("FAIL directed_pair1: got %h expected %h", obs[base+1], e1);
      end
    end
    checks++;
    if (pe_total != pe0) begin
      errors++;
      $display("FAIL directed_parity: got %0d errors expected 0", pe_total - pe0);
    end
    dt = lock_t - start_t;
    checks++;
    if (dt < 8.0 * Ui - 30.0 || dt > 8.0 * Ui + 150.0) begin
      errors++;
      $display("FAIL directed_lock_time: got %0.1f ns expected near %0.1f ns", dt, 8.0 * Ui);
    end
    checks++;
    if (sample_left !== 24'h000001 || sample_right !== 24'hFFFFFF || block_start !== 1'b0) begin
      errors++;
      $display("FAIL directed_hold: got %h/%h/%b expected 000001/ffffff/0",
               sample_left, sample_right, block_start);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL directed_idle_unlock: got %b expected 0", locked);
    end
  endtask

  task automatic test_parity();
    int base, pe0;
    stim.delete();
    stim.push_back(mk(2'd0, 24'($urandom), 1'b0, 1'b0));
    stim.push_back(mk(2'd2, 24'($urandom), 1'b0, 1'b0));
    stim.push_back(mk(2'd1, 24'($urandom), 1'b0, 1'b0));
    stim.push_back(mk(2'd2, 24'($urandom), 1'b1, 1'b0));
    build_model();
    base = obs.size();
    pe0  = pe_total;
    run_stream(1'b0);
    checks++;
    if (obs.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL parity_count: got %0d expected %0d", obs.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs.size(); i++) begin
      checks++;
      if (obs[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL parity_pair%0d: got %h expected %h", i, obs[base+i], exp_q[i]);
      end
    end
    checks++;
    if (pe_total - pe0 != exp_pe) begin
      errors++;
      $display("FAIL parity_strobes: got %0d expected %0d", pe_total - pe0, exp_pe);
    end
    checks++;
    if ({block_start, sample_left, sample_right} !== exp_q[exp_q.size()-1]) begin
      errors++;
      $display("FAIL parity_hold: got %h expected %h",
               {block_start, sample_left, sample_right}, exp_q[exp_q.size()-1]);
    end
  endtask

  task automatic test_timeout_relock();
    int base, lr0;
    stim.delete();
    stim.push_back(mk(2'd0, 24'($urandom), 1'b0, 1'b0));
    stim.push_back(mk(2'd2, 24'($urandom), 1'b0, 1'b0));
    stim.push_back(mk(2'd1, 24'($urandom), 1'b0, 1'b1));
    stim.push_back(mk(2'd1, 24'($urandom), 1'b0, 1'b0));
    stim.push_back(mk(2'd2, 24'($urandom), 1'b0, 1'b0));
    build_model();
    base = obs.size();
    lr0  = lock_rises;
    run_stream(1'b0);
    checks++;
    if (obs.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL timeout_count: got %0d expected %0d", obs.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs.size(); i++) begin
      checks++;
      if (obs[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL timeout_pair%0d: got %h expected %h", i, obs[base+i], exp_q[i]);
      end
    end
    checks++;
    if (lock_rises - lr0 != 2) begin
      errors++;
      $display("FAIL timeout_relock: got %0d lock rises expected 2", lock_rises - lr0);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL timeout_unlock: got %b expected 0", locked);
    end
  endtask

  task automatic test_inverted();
    int base, pe0;
    stim.delete();
    for (int i = 0; i < 3; i++) begin
      stim.push_back(mk((i == 0) ? 2'd0 : 2'd1, 24'($urandom), 1'b0, 1'b0));
      stim.push_back(mk(2'd2, 24'($urandom), 1'b0, 1'b0));
    end
    build_model();
    for (int pol = 0; pol < 2; pol++) begin
      base = obs.size();
      pe0  = pe_total;
      run_stream(pol[0]);
      checks++;
      if (obs.size() - base != exp_q.size()) begin
        errors++;
        $display("FAIL invert%0d_count: got %0d expected %0d", pol, obs.size() - base,
                 exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < obs.size(); i++) begin
        checks++;
        if (obs[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL invert%0d_pair%0d: got %h expected %h", pol, i, obs[base+i], exp_q[i]);
        end
      end
      checks++;
      if (pe_total != pe0) begin
        errors++;
        $display("FAIL invert%0d_parity: got %0d expected 0", pol, pe_total - pe0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    stim.delete();
    stim.push_back(mk(2'd0, 24'h5A5A5A, 1'b0, 1'b0));
    stim.push_back(mk(2'd2, 24'hC3C3C3, 1'b0, 1'b0));
    run_stream(1'b0);
    // Start a fresh subframe by hand and cut it off with reset.
    send_pulse(3);
    send_pulse(1);
    send_pulse(1);
    send_pulse(3);
    send_pulse(2);
    send_pulse(2);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_locked_before: got %b expected 1", locked);
    end
    #37;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sample_left, sample_right, sample_valid, block_start, locked, parity_error} !== 52'd0)
    begin
      errors++;
      $display("FAIL reset_mid_clear: got %h/%h v=%b b=%b l=%b p=%b expected all zero",
               sample_left, sample_right, sample_valid, block_start, locked, parity_error);
    end
    wait_clks(3);
    reset_n = 1'b1;
    stim.delete();
    stim.push_back(mk(2'd1, 24'h876543, 1'b0, 1'b0));
    stim.push_back(mk(2'd2, 24'h0F0F0F, 1'b0, 1'b0));
    build_model();
    base = obs.size();
    run_stream(1'b1);
    checks++;
    if (obs.size() - base != 1) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d expected 1", obs.size() - base);
    end
    if (obs.size() - base >= 1) begin
      checks++;
      if (obs[base] !== exp_q[0]) begin
        errors++;
        $display("FAIL reset_mid_pair: got %h expected %h", obs[base], exp_q[0]);
      end
    end
  endtask

  task automatic test_random();
    int base, pe0;
    stim.delete();
    for (int i = 0; i < 10; i++) begin
      stim.push_back(mk(2'($urandom_range(2)), 24'($urandom), ($urandom_range(5) == 0),
                        1'b0));
    end
    build_model();
    base = obs.size();
    pe0  = pe_total;
    run_stream(1'($urandom_range(1)));
    checks++;
    if (obs.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d expected %0d", obs.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs.size(); i++) begin
      checks++;
      if (obs[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_pair%0d: got %h expected %h", i, obs[base+i], exp_q[i]);
      end
    end
    checks++;
    if (pe_total - pe0 != exp_pe) begin
      errors++;
      $display("FAIL random_parity: got %0d expected %0d", pe_total - pe0, exp_pe);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_parity();
    test_timeout_relock();
    test_inverted();
    test_reset_mid();
    for (int r = 0; r < 3; r++) test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
